// File: rtl/hd44780_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hd44780_pkg
// Description : Shared delays, HD44780 opcodes and controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package hd44780_pkg;

    // Datasheet delays in microseconds
    localparam longint unsigned US_PWR  = 64'd40000;
    localparam longint unsigned US_W1   = 64'd4100;
    localparam longint unsigned US_W2   = 64'd100;
    localparam longint unsigned US_EXEC = 64'd50;
    localparam longint unsigned US_LONG = 64'd2000;

    localparam logic [7:0] OP_CLEAR    = 8'h01;
    localparam logic [7:0] OP_HOME     = 8'h02;
    localparam logic [7:0] OP_ENTRY    = 8'h06;
    localparam logic [7:0] OP_DISPCTL  = 8'h0C;
    localparam logic [7:0] OP_FUNCSET  = 8'h20;
    localparam logic [7:0] OP_SETDDRAM = 8'h80;
    localparam logic [7:0] OP_WAKE     = 8'h30;

    typedef enum logic [2:0] {
        S_PWR_WAIT  = 3'd0,
        S_WAKE      = 3'd1,
        S_SET4      = 3'd2,
        S_INIT_SEQ  = 3'd3,
        S_IDLE      = 3'd4,
        S_XFER      = 3'd5,
        S_EXEC_WAIT = 3'd6
    } state_e;

    // Clock cycles covering a delay, never less than one
    function automatic longint unsigned cyc(input longint unsigned us,
                                            input longint unsigned hz);
        longint unsigned t;
        t = (us * hz + 64'd999999) / 64'd1000000;
        return (t == 64'd0) ? 64'd1 : t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hd44780_ctrl_bus.sv
`default_nettype none
// ============================================================================
// Module      : hd44780_bus
// Description : One LCD write: setup / enable / hold per transfer, then wait.
// Revision    : 1.0 - initial release
// ============================================================================
module hd44780_bus #(
    parameter int BUS_W = 4,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_i,
    input  logic             rs_i,
    input  logic [7:0]       byte_i,
    input  logic             two_i,
    input  logic [CW-1:0]    wait_i,
    output logic             last_hold_o,
    output logic             done_o,
    output logic             lcd_en_o,
    output logic             lcd_rs_o,
    output logic [BUS_W-1:0] lcd_data_o
);

    localparam logic [2:0] B_IDLE  = 3'd0;
    localparam logic [2:0] B_SETUP = 3'd1;
    localparam logic [2:0] B_EN    = 3'd2;
    localparam logic [2:0] B_HOLD  = 3'd3;
    localparam logic [2:0] B_WAIT  = 3'd4;

    logic [2:0]       phase_q, phase_d;
    logic             nib2_q, nib2_d;
    logic [BUS_W-1:0] nxt_q, nxt_d;
    logic [BUS_W-1:0] data_q, data_d;
    logic             rs_q, rs_d;
    logic             en_q, en_d;
    logic [CW-1:0]    wait_q, wait_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BUS_W-1:0] first_w, second_w;
    logic             wait_end;

    if (BUS_W == 8) begin : g_bus8
        assign first_w  = byte_i;
        assign second_w = byte_i;
    end else begin : g_bus4
        assign first_w  = byte_i[7:4];
        assign second_w = byte_i[3:0];
    end

    assign wait_end    = (cnt_q == wait_q - 1'b1);
    assign last_hold_o = (phase_q == B_HOLD) && !nib2_q;
    assign done_o      = (phase_q == B_WAIT) && wait_end;
    assign lcd_en_o    = en_q;
    assign lcd_rs_o    = rs_q;
    assign lcd_data_o  = data_q;

    always_comb begin
        phase_d = phase_q;
        nib2_d  = nib2_q;
        nxt_d   = nxt_q;
        data_d  = data_q;
        rs_d    = rs_q;
        en_d    = en_q;
        wait_d  = wait_q;
        cnt_d   = cnt_q;
        case (phase_q)
            B_IDLE: begin
                if (req_i) begin
                    rs_d    = rs_i;
                    data_d  = first_w;
                    nxt_d   = second_w;
                    nib2_d  = two_i;
                    wait_d  = wait_i;
                    phase_d = B_SETUP;
                end
            end
            B_SETUP: begin
                en_d    = 1'b1;
                phase_d = B_EN;
            end
            B_EN: begin
                en_d    = 1'b0;
                phase_d = B_HOLD;
            end
            B_HOLD: begin
                // Low nibble goes out only after the high nibble's hold cycle
                if (nib2_q) begin
                    data_d  = nxt_q;
                    nib2_d  = 1'b0;
                    phase_d = B_SETUP;
                end else begin
                    cnt_d   = '0;
                    phase_d = B_WAIT;
                end
            end
            B_WAIT: begin
                if (wait_end) begin
                    phase_d = B_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: phase_d = B_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= B_IDLE;
            nib2_q  <= 1'b0;
            nxt_q   <= '0;
            data_q  <= '0;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            nib2_q  <= nib2_d;
            nxt_q   <= nxt_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            en_q    <= en_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hd44780_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hd44780_ctrl
// Description : HD44780 power-on init plus byte-wide command/data writer.
// Revision    : 1.0 - initial release
// ============================================================================
module hd44780_ctrl
    import hd44780_pkg::*;
#(
    parameter int CLK_HZ = 1000,
    parameter int BUS_W  = 4,
    parameter int LINES2 = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_rs,
    input  logic [7:0]       cmd_data,
    output logic             init_done,
    output logic             lcd_en,
    output logic             lcd_rs,
    output logic [BUS_W-1:0] lcd_data
);

    localparam longint unsigned T_PWR_L = cyc(US_PWR, 64'(CLK_HZ));
    localparam int              CW      = $clog2(T_PWR_L + 64'd1);

    localparam logic [CW-1:0] T_PWR_M1 = CW'(T_PWR_L - 64'd1);
    localparam logic [CW-1:0] T_W1     = CW'(cyc(US_W1,   64'(CLK_HZ)));
    localparam logic [CW-1:0] T_W2     = CW'(cyc(US_W2,   64'(CLK_HZ)));
    localparam logic [CW-1:0] T_EXEC   = CW'(cyc(US_EXEC, 64'(CLK_HZ)));
    localparam logic [CW-1:0] T_LONG   = CW'(cyc(US_LONG, 64'(CLK_HZ)));

    localparam logic [7:0] FUNCSET_B = OP_FUNCSET
                                     | ((BUS_W == 8) ? 8'h10 : 8'h00)
                                     | ((LINES2 != 0) ? 8'h08 : 8'h00);

    state_e        state_q, state_d;
    state_e        ret_q, ret_d;
    logic [2:0]    step_q, step_d;
    logic [CW-1:0] pwr_cnt_q, pwr_cnt_d;
    logic          init_done_q, init_done_d;

    logic          req;
    logic          req_rs;
    logic [7:0]    req_byte;
    logic          req_two;
    logic [CW-1:0] req_wait;
    logic [7:0]    init_byte;
    logic          bus_last_hold;
    logic          bus_done;

    // Clear and home need the long execution time
    function automatic logic [CW-1:0] exec_wait(input logic rs, input logic [7:0] b);
        return (!rs && (b == OP_CLEAR || b == OP_HOME || b == 8'h03)) ? T_LONG : T_EXEC;
    endfunction

    always_comb begin
        case (step_q)
            3'd0:    init_byte = FUNCSET_B;
            3'd1:    init_byte = OP_DISPCTL;
            3'd2:    init_byte = OP_ENTRY;
            default: init_byte = OP_CLEAR;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        step_d      = step_q;
        pwr_cnt_d   = pwr_cnt_q;
        init_done_d = init_done_q;
        req         = 1'b0;
        req_rs      = 1'b0;
        req_byte    = OP_WAKE;
        req_two     = 1'b0;
        req_wait    = T_EXEC;
        case (state_q)
            S_PWR_WAIT: begin
                if (pwr_cnt_q == T_PWR_M1) begin
                    state_d = S_WAKE;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + 1'b1;
                end
            end
            S_WAKE: begin
                if (step_q == 3'd3) begin
                    step_d  = 3'd0;
                    state_d = (BUS_W == 4) ? S_SET4 : S_INIT_SEQ;
                end else begin
                    req      = 1'b1;
                    req_wait = (step_q == 3'd0) ? T_W1 : T_W2;
                    step_d   = step_q + 1'b1;
                    ret_d    = S_WAKE;
                    state_d  = S_XFER;
                end
            end
            S_SET4: begin
                if (step_q == 3'd1) begin
                    step_d  = 3'd0;
                    state_d = S_INIT_SEQ;
                end else begin
                    req      = 1'b1;
                    req_byte = OP_FUNCSET;
                    step_d   = 3'd1;
                    ret_d    = S_SET4;
                    state_d  = S_XFER;
                end
            end
            S_INIT_SEQ: begin
                if (step_q == 3'd4) begin
                    step_d      = 3'd0;
                    init_done_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    req      = 1'b1;
                    req_byte = init_byte;
                    req_two  = (BUS_W == 4);
                    req_wait = exec_wait(1'b0, init_byte);
                    step_d   = step_q + 1'b1;
                    ret_d    = S_INIT_SEQ;
                    state_d  = S_XFER;
                end
            end
            S_IDLE: begin
                if (cmd_valid && init_done_q) begin
                    req      = 1'b1;
                    req_rs   = cmd_rs;
                    req_byte = cmd_data;
                    req_two  = (BUS_W == 4);
                    req_wait = exec_wait(cmd_rs, cmd_data);
                    ret_d    = S_IDLE;
                    state_d  = S_XFER;
                end
            end
            S_XFER: begin
                if (bus_last_hold) begin
                    state_d = S_EXEC_WAIT;
                end
            end
            S_EXEC_WAIT: begin
                if (bus_done) begin
                    state_d = ret_q;
                end
            end
            default: state_d = S_PWR_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_PWR_WAIT;
            ret_q       <= S_PWR_WAIT;
            step_q      <= 3'd0;
            pwr_cnt_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            step_q      <= step_d;
            pwr_cnt_q   <= pwr_cnt_d;
            init_done_q <= init_done_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE) && init_done_q;
    assign init_done = init_done_q;

    hd44780_bus #(
        .BUS_W (BUS_W),
        .CW    (CW)
    ) u_bus (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req),
        .rs_i        (req_rs),
        .byte_i      (req_byte),
        .two_i       (req_two),
        .wait_i      (req_wait),
        .last_hold_o (bus_last_hold),
        .done_o      (bus_done),
        .lcd_en_o    (lcd_en),
        .lcd_rs_o    (lcd_rs),
        .lcd_data_o  (lcd_data)
    );

endmodule
`default_nettype wire

// File: doc/hd44780_ctrl.md
# hd44780_ctrl

Parametrised HD44780 character-LCD controller: runs the power-on initialisation, then accepts command/data bytes over a valid/ready handshake and writes them to the panel. It supports a 4-bit or 8-bit bus, with all delays derived from the clock rate. It sits between display-content logic (clock, status text) and the LCD pins, so those producers deal in whole bytes and never sequence enable pulses.

## Interface
- `CLK_HZ`, 1000: clk frequency in Hz; all delays derive from it.
- `BUS_W`, 4: LCD data bus width; legal values are 4 or 8.
- `LINES2`, 1: 1 selects two-line mode (function-set N bit), 0 selects one line.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: a byte is offered.
- `cmd_ready` out 1: the controller can accept a byte this cycle.
- `cmd_rs` in 1: 0 = instruction, 1 = DDRAM/CGRAM data.
- `cmd_data` in 8: the byte.
- `init_done` out 1: init sequence complete; sticky until reset.
- `lcd_en` out 1: E pin.
- `lcd_rs` out 1: RS pin.
- `lcd_data` out BUS_W: D7..D4 (4-bit mode) or D7..D0 (8-bit mode).

## Operation
- Delay helper: `cyc(us) = max(1, ceil(us*CLK_HZ/1e6))`, evaluated in 64-bit constant arithmetic.
- Constants:
  - T_PWR = cyc(40000)
  - T_W1 = cyc(4100)
  - T_W2 = cyc(100)
  - T_EXEC = cyc(50)
  - T_LONG = cyc(2000)
- FSM states: PWR_WAIT → WAKE → SET4 → INIT_SEQ → IDLE → XFER → EXEC_WAIT → IDLE.
- PWR_WAIT: count T_PWR cycles.
- WAKE: three transfers of 0x3 on the upper nibble (in 8-bit mode the full bus carries 0x30), with rs=0.
  - Waits after each transfer are T_W1, T_W2 and T_W2 respectively.
- SET4: only when BUS_W=4. One nibble 0x2, followed by a T_EXEC wait. When BUS_W=8 this state is skipped.
- INIT_SEQ: four instruction bytes, each a full XFER followed by EXEC_WAIT:
  - function set = 0x20 | (BUS_W==8)<<4 | LINES2<<3
  - 0x0C (display on)
  - 0x06 (entry mode)
  - 0x01 (clear), which uses the T_LONG wait
- init_done rises on entry to IDLE after INIT_SEQ.
- IDLE: cmd_ready=1 if and only if in IDLE and init_done=1.
  - On cmd_valid & cmd_ready, latch rs and data, then enter XFER.
  - Inputs are not sampled outside the accept cycle.
- XFER, per bus transfer:
  - 1 setup cycle: rs/data driven, en=0.
  - 1 cycle with en=1.
  - 1 hold cycle: en=0, rs/data unchanged.
  - In 4-bit mode there are two transfers: high nibble first, then low nibble.
- EXEC_WAIT: T_LONG when the byte is an instruction (rs=0) with data 0x01, 0x02 or 0x03; otherwise T_EXEC. Then return to IDLE.
- lcd_rs and lcd_data hold their last driven value while idle.

## Timing
- Reset values: lcd_en=0, lcd_rs=0, lcd_data=0, cmd_ready=0, init_done=0; FSM in PWR_WAIT with its counter cleared.
- Reset mid-transfer: the next cycle shows reset values and init restarts from PWR_WAIT. The half-written byte is abandoned.
- cmd_ready deasserts in the cycle after acceptance.
- Minimum issue interval (cycles from acceptance until cmd_ready returns):
  - 4-bit mode: 1 + 6 + T_EXEC
  - 8-bit mode: 1 + 3 + T_EXEC
- Every lcd_en high pulse lasts exactly 1 cycle. It is always preceded and followed by at least 1 cycle of stable rs/data with en=0.
- Waits are counted from the cycle after the hold cycle. The counter width is clog2(T_PWR+1).
- Holding cmd_valid high continuously gives back-to-back bytes at the minimum interval, with no byte lost or duplicated.

## Structure
- Package `hd44780_pkg`:
  - `cyc()` function
  - delay-in-µs constants
  - instruction opcodes: CLEAR, HOME, ENTRY, DISPCTL, FUNCSET, SETDDRAM
  - FSM state enum
- Sub-module `hd44780_bus`: takes a nibble or byte request plus a wait length and performs the setup / en / hold / wait sequence. It reports done, and the main FSM sequences it.

## Test plan
- CLK_HZ=1000, BUS_W=4, LINES2=1, reset released → first en pulse at cycle T_PWR+2 with data=0x3.
  - Nibble stream is 3,3,3,2,2,8,0,C,0,6,0,1.
  - init_done rises 2 cycles after the clear's T_LONG wait ends.
- BUS_W=8 → lcd_data shows 0x30 three times, then 0x38, 0x0C, 0x06, 0x01; no 0x2 nibble appears.
- After init, send rs=1, data=0x41 ('A') → 4-bit mode emits nibbles 4 then 1 with rs=1. cmd_ready returns after exactly 7+T_EXEC cycles.
- Send rs=0, data=0x01, then rs=0, data=0x80 back-to-back with valid held → the gap after 0x01 is T_LONG and after 0x80 is T_EXEC; each byte is accepted exactly once.
- Assert reset between the two nibbles of a data byte → the next cycle has en=0, data=0, cmd_ready=0, and the full init sequence repeats.
- cmd_valid held high during init → no acceptance before init_done; the first byte is accepted in the first cycle init_done=1.
